// File: rtl/otn_arq_pkg.sv
// Shared encodings for the OTN ARQ transmitter: FSM states, ACK line levels
// and a counter-width helper.
package otn_arq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SEND     = 3'd2,
    ACK_WAIT = 3'd3,
    ACK_READ = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic ACK_GOOD  = 1'b1;
  localparam logic ACK_START = 1'b0;
  localparam logic ACK_IDLE  = 1'b1;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/otn_frame_buf.sv
// Frame buffer: simple dual-port RAM, one write port, one read port with a
// single registered read cycle.
module otn_frame_buf
  import otn_arq_pkg::*;
#(
  parameter int DEPTH  = 4166,
  parameter int DATA_W = 8,
  parameter int ADDR_W = cnt_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/otn_arq_tx.sv
// OTN sender: buffers one frame, serialises it LSB-first and retransmits on a
// bad or missing ACK. Build option: ARQ_TIMEOUT_EN enables the ACK timeout.
module otn_arq_tx
  import otn_arq_pkg::*;
#(
  parameter int FRAME_BYTES      = 4166,
  parameter int DATA_W           = 8,
  parameter int CLKS_PER_BIT     = 20,
  parameter int MAX_RETRIES      = 3,
  parameter int ACK_TIMEOUT_BITS = 64,
  parameter int DONE_HOLD        = 40
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_baud_tick,
  input  logic [DATA_W-1:0]                    i_data,
  input  logic                                 i_valid,
  input  logic                                 i_sof,
  output logic                                 o_ready,
  input  logic                                 i_arq_en,
  output logic                                 o_tx_ser,
  input  logic                                 i_ack_ser,
  output logic                                 o_busy,
  output logic                                 o_send_complete,
  output logic                                 o_send_failed,
  output logic [cnt_w(MAX_RETRIES+1)-1:0]      o_retry_cnt,
  output logic [2:0]                           o_state
);

  localparam int ADDR_W = cnt_w(FRAME_BYTES);
  localparam int BIT_W  = cnt_w(DATA_W);
  localparam int DIV_W  = cnt_w(CLKS_PER_BIT);
  localparam int RTRY_W = cnt_w(MAX_RETRIES + 1);
  localparam int HOLD_W = cnt_w(DONE_HOLD);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [RTRY_W-1:0] MAX_RTRY  = RTRY_W'(MAX_RETRIES);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(DONE_HOLD - 1);

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div;
  logic                bit_en, beat, wr_en, arq_q, failed_q;
  logic                ack_p0, ack_p1;
  logic [ADDR_W-1:0]   wr_ptr, wr_addr, byte_cnt, byte_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [RTRY_W-1:0]   retry_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DATA_W-1:0]   rd_data;
  logic                load_end, frame_end, start_seen, timeout_hit;
  logic                good_ack, bad_ack, retry_ok;

  assign beat      = i_valid && o_ready;
  assign bit_en    = i_baud_tick && (div == LAST_DIV);
  assign wr_en     = beat && ((state == LOAD) || i_sof);
  assign wr_addr   = i_sof ? '0 : wr_ptr;
  assign load_end  = beat && (state == LOAD) && !i_sof && (wr_ptr == LAST_ADDR);
  assign frame_end = (state == SEND) && bit_en && (bit_cnt == LAST_BIT) &&
                     (byte_cnt == LAST_ADDR);
  assign start_seen = (state == ACK_WAIT) && bit_en && (ack_p1 == ACK_START);
  assign good_ack  = (state == ACK_READ) && bit_en && (ack_p1 == ACK_GOOD);
  assign bad_ack   = ((state == ACK_READ) && bit_en && (ack_p1 != ACK_GOOD)) || timeout_hit;
  assign retry_ok  = retry_cnt < MAX_RTRY;

`ifdef ARQ_TIMEOUT_EN
  localparam int TO_W = cnt_w(ACK_TIMEOUT_BITS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT_BITS - 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || state != ACK_WAIT) to_cnt <= '0;
    else if (bit_en)                to_cnt <= to_cnt + 1'b1;
  end

  // A start bit on the final period wins over the timeout.
  assign timeout_hit = (state == ACK_WAIT) && bit_en && (ack_p1 != ACK_START) &&
                       (to_cnt == TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^ACK_TIMEOUT_BITS;
  assign timeout_hit    = 1'b0;
`endif

  // ACK line synchroniser stages
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_p0 <= ACK_IDLE;
      ack_p1 <= ACK_IDLE;
    end else begin
      ack_p0 <= i_ack_ser;
      ack_p1 <= ack_p0;
    end
  end

  // Baud divider restarts on SEND entry so bit 0 gets a full period.
  always_ff @(posedge i_clk) begin
    if (i_rst || (state_nxt == SEND && state != SEND)) div <= '0;
    else if (i_baud_tick) div <= (div == LAST_DIV) ? '0 : div + 1'b1;
  end

  // Read address runs one step ahead so rd_data always holds byte_cnt's byte.
  always_comb begin
    byte_nxt = byte_cnt;
    bit_nxt  = bit_cnt;
    if (state != SEND) begin
      byte_nxt = '0;
      bit_nxt  = '0;
    end else if (bit_en) begin
      if (bit_cnt == LAST_BIT) begin
        bit_nxt  = '0;
        byte_nxt = (byte_cnt == LAST_ADDR) ? '0 : byte_cnt + 1'b1;
      end else begin
        bit_nxt = bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      wr_ptr    <= '0;
      arq_q     <= 1'b0;
      retry_cnt <= '0;
      hold_cnt  <= '0;
      failed_q  <= 1'b0;
    end else begin
      byte_cnt <= byte_nxt;
      bit_cnt  <= bit_nxt;
      if (wr_en)    wr_ptr <= wr_addr + 1'b1;
      if (load_end) arq_q  <= i_arq_en;
      if (state == IDLE)            retry_cnt <= '0;
      else if (bad_ack && retry_ok) retry_cnt <= retry_cnt + 1'b1;
      hold_cnt <= (state == DONE) ? hold_cnt + 1'b1 : '0;
      failed_q <= bad_ack && !retry_ok;
    end
  end

  otn_frame_buf #(
    .DEPTH  (FRAME_BYTES),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .i_clk   (i_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (i_data),
    .rd_addr (byte_nxt),
    .rd_data (rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (beat && i_sof) state_nxt = LOAD;
      LOAD:     if (load_end)      state_nxt = SEND;
      SEND:     if (frame_end)     state_nxt = arq_q ? ACK_WAIT : DONE;
      ACK_WAIT: begin
        if (start_seen)   state_nxt = ACK_READ;
        else if (bad_ack) state_nxt = retry_ok ? SEND : IDLE;
      end
      ACK_READ: begin
        if (good_ack)     state_nxt = DONE;
        else if (bad_ack) state_nxt = retry_ok ? SEND : IDLE;
      end
      DONE:     if (hold_cnt == LAST_HOLD) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready         = (state == IDLE) || (state == LOAD);
    o_busy          = (state != IDLE);
    o_send_complete = (state == DONE);
    o_send_failed   = failed_q;
    o_retry_cnt     = retry_cnt;
    o_state         = state;
    o_tx_ser        = (state == SEND) ? rd_data[bit_cnt] : 1'b1;
  end

endmodule
